// File: rtl/demux1to10_32bit_reg_if.sv
// Handshake bundle for the registered 1:10 word distributor.
// Producer side drives in_*, destination side drives out_ready.
interface demux1to10_32bit_reg_if #(
    parameter int DW    = 32,
    parameter int NPORT = 10,
    parameter int SELW  = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [SELW-1:0]  in_sel;
    logic [DW-1:0]    out_data;
    logic [NPORT-1:0] out_valid;
    logic [NPORT-1:0] out_ready;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux1to10_32bit_reg.sv
// Registered 1-to-NPORT distributor with a one-entry output register.
// Out-of-range selects are dropped and counted in a saturating counter.
module demux1to10_32bit_reg #(
    parameter int DW    = 32,
    parameter int NPORT = 10,
    parameter int SELW  = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux1to10_32bit_reg_if.slave bus,
    output logic                  drop_pulse,
    output logic [CNTW-1:0]       drop_cnt,
    input  logic                  drop_clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [NPORT-1:0] vld_q, vld_d;
    logic             drop_q, drop_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             drain;
    logic             rdy;
    logic             accept;
    logic             legal;
    logic [NPORT-1:0] dec;

    // Extra MSB keeps the compare valid even when 2**SELW == NPORT.
    assign legal  = {1'b0, bus.in_sel} < (SELW+1)'(NPORT);
    assign dec    = NPORT'(1) << bus.in_sel;
    assign drain  = (state_q == FULL) && |(vld_q & bus.out_ready);
    assign rdy    = (state_q == EMPTY) || drain;
    assign accept = bus.in_valid && rdy;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        drop_d  = 1'b0;
        unique case (1'b1)
            accept && legal: begin
                state_d = FULL;
                data_d  = bus.in_data;
                vld_d   = dec;
            end
            accept && !legal: begin
                state_d = EMPTY;
                vld_d   = '0;
                drop_d  = 1'b1;
            end
            !accept && drain: begin
                state_d = EMPTY;
                vld_d   = '0;
            end
            default: ;
        endcase
    end

    // Clear wins over a same-cycle drop.
    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            drop_clr:
                cnt_d = '0;
            !drop_clr && drop_d && (cnt_q != '1):
                cnt_d = cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            vld_q   <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_valid = vld_q;
    assign drop_pulse    = drop_q;
    assign drop_cnt      = cnt_q;

endmodule
